periph_bus_arbiter: RTL

- Shares the single-slave memory-mapped peripheral bus, as used by the timer, between two masters: M0 (core load/store unit) and M1 (debug/DMA port).
- Each master uses a req/ack handshake. The arbiter picks one request round-robin and drives the slave's bus_r_*/bus_w_* ports for exactly one cycle.
- For reads, it registers the returned data and returns it with a one-cycle ack pulse.
- Sits between the masters and the address decoder that feeds the peripherals.

---
 rtl/periph_bus_arbiter_pkg.sv | 32 +++
 rtl/periph_bus_arbiter_rr_arb2.sv | 24 ++
 rtl/periph_bus_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: bus widths, FSM state
// encoding, timer register offsets and the two-way round-robin pick helper.
package periph_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  // Two-bit state encoding; code 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } bus_state_t;

  // Register offsets of the timer peripheral living on this bus.
  localparam logic [31:0] TIMER_CNT_OFF  = 32'h0000_0000;
  localparam logic [31:0] TIMER_CTRL_OFF = 32'h0000_0004;

  // Pick the winner among two requesters; on contention the master that
  // did not own the last transaction wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic idx;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last_grant;
      default: idx = 1'b0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// Combinational two-requester round-robin arbiter, shared with other fabrics.
module periph_bus_arbiter_rr_arb2
  import periph_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Decode request vector into a valid flag and the winning index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (req != 2'b00) begin
      gnt_valid = 1'b1;
      gnt_idx   = rr_pick(req, last_grant);
    end else begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the single-slave peripheral bus. A granted request
// is latched, driven onto the slave port for one cycle, and answered with a
// one-cycle ack; read data is registered and shared by both masters.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_r_en,
  output logic [ADDR_W-1:0] bus_r_addr,
  input  logic [DATA_W-1:0] bus_r_data,
  output logic              bus_w_en,
  output logic [ADDR_W-1:0] bus_w_addr,
  output logic [DATA_W-1:0] bus_w_data,
  output logic              grant
);

  logic              gnt_valid_s;
  logic              gnt_idx_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  bus_state_t        state_r;
  logic              owner_r;
  logic              we_r;
  logic              last_grant_r;
  logic              m0_ack_r;
  logic              m1_ack_r;
  logic [DATA_W-1:0] rdata_r;
  logic              bus_r_en_r;
  logic [ADDR_W-1:0] bus_r_addr_r;
  logic              bus_w_en_r;
  logic [ADDR_W-1:0] bus_w_addr_r;
  logic [DATA_W-1:0] bus_w_data_r;

  periph_bus_arbiter_rr_arb2 u_rr_arb2 (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt_idx    (gnt_idx_s)
  );

  // Route the winning master's transaction fields toward the latch.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt_idx_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Transaction FSM: latch the winner, strobe the slave once, then ack.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      last_grant_r <= 1'b1;
      m0_ack_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      rdata_r      <= '0;
      bus_r_en_r   <= 1'b0;
      bus_r_addr_r <= '0;
      bus_w_en_r   <= 1'b0;
      bus_w_addr_r <= '0;
      bus_w_data_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          m0_ack_r <= 1'b0;
          m1_ack_r <= 1'b0;
          if (gnt_valid_s) begin
            owner_r      <= gnt_idx_s;
            we_r         <= sel_we_s;
            bus_w_en_r   <= sel_we_s;
            bus_r_en_r   <= ~sel_we_s;
            bus_w_addr_r <= sel_we_s ? sel_addr_s  : '0;
            bus_w_data_r <= sel_we_s ? sel_wdata_s : '0;
            bus_r_addr_r <= sel_we_s ? '0 : sel_addr_s;
            state_r      <= ST_ISSUE;
          end else begin
            bus_r_en_r   <= 1'b0;
            bus_r_addr_r <= '0;
            bus_w_en_r   <= 1'b0;
            bus_w_addr_r <= '0;
            bus_w_data_r <= '0;
            state_r      <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // Slave read data is combinational, so it is valid on this edge.
          if (!we_r) begin
            rdata_r <= bus_r_data;
          end else begin
            rdata_r <= rdata_r;
          end
          bus_r_en_r   <= 1'b0;
          bus_r_addr_r <= '0;
          bus_w_en_r   <= 1'b0;
          bus_w_addr_r <= '0;
          bus_w_data_r <= '0;
          m0_ack_r     <= ~owner_r;
          m1_ack_r     <= owner_r;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          m0_ack_r     <= 1'b0;
          m1_ack_r     <= 1'b0;
          last_grant_r <= owner_r;
          state_r      <= ST_IDLE;
        end
        default: begin
          m0_ack_r     <= 1'b0;
          m1_ack_r     <= 1'b0;
          bus_r_en_r   <= 1'b0;
          bus_r_addr_r <= '0;
          bus_w_en_r   <= 1'b0;
          bus_w_addr_r <= '0;
          bus_w_data_r <= '0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ack     = m0_ack_r;
  assign m1_ack     = m1_ack_r;
  assign m0_rdata   = rdata_r;
  assign m1_rdata   = rdata_r;
  assign bus_r_en   = bus_r_en_r;
  assign bus_r_addr = bus_r_addr_r;
  assign bus_w_en   = bus_w_en_r;
  assign bus_w_addr = bus_w_addr_r;
  assign bus_w_data = bus_w_data_r;
  assign grant      = owner_r;

endmodule
